frame_scheduler: RTL and testbench
==================================

FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of update requesters and pixel layers.
REQ-002 SHALL have parameter TIMEOUT, default 1024: maximum grant duration in clk cycles.
REQ-003 SHALL have parameter BG_RGB, default 3'b000: background colour.
REQ-004 SHALL have port clk, input, 1: 25 MHz pixel clock, the same clock that feeds VGADriver; one clock domain.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port vga_vsync, input, 1: VGADriver vsync, active-low pulse, not assumed synchronous to clk.
REQ-007 SHALL have port upd_req, input, NUM_REQ: per-requester request for an update slot this frame.
REQ-008 SHALL have port upd_done, input, NUM_REQ: per-requester single-cycle completion strobe.
REQ-009 SHALL have port upd_gnt, output, NUM_REQ: one-hot grant, registered.
REQ-010 SHALL have port layer_rgb, input, 3*NUM_REQ: layer i colour in bits [3i+2:3i].
REQ-011 SHALL have port layer_valid, input, NUM_REQ: layer i covers the current pixel.
REQ-012 SHALL have port pixel_rgb, output, 3: merged colour to VGADriver, registered.
REQ-013 SHALL have port frame_tick, output, 1: one-cycle pulse at frame start.
REQ-014 SHALL have port frame_count, output, 16: frames since reset.
REQ-015 SHALL have port busy, output, 1: high whenever the FSM is not in IDLE.
REQ-016 SHALL have port overrun, output, 1: sticky scheduling-error flag.
REQ-017 SHALL have port overrun_clr, input, 1: synchronous clear for overrun.

Function
REQ-018 SHALL pass vga_vsync through a two-flop synchronizer and detect its falling edge on the synchronized signal.
REQ-019 SHALL assert frame_tick for exactly one cycle, in the cycle after the synchronized falling edge is detected.
REQ-020 SHALL increment frame_count on every frame_tick, wrapping from 16'hFFFF to 0.
REQ-021 SHALL use three FSM states: IDLE, SCAN and GRANT.
REQ-022 IDLE: on frame_tick, SHALL latch upd_req into pending[NUM_REQ-1:0] and enter SCAN in the next cycle.
REQ-023 SCAN: if pending is 0, SHALL return to IDLE; otherwise it SHALL select the lowest set index k, assert upd_gnt[k] from the next cycle and enter GRANT.
REQ-024 GRANT: on upd_done[k], SHALL deassert upd_gnt[k] the next cycle, clear pending[k] and enter SCAN.
REQ-025 SHALL ignore upd_done bits other than the granted bit k.
REQ-026 SHALL deassert upd_gnt[k] after exactly TIMEOUT cycles high if upd_done[k] has not arrived, set overrun, clear pending[k] and enter SCAN.
REQ-027 SHALL treat upd_done[k] and timeout in the same cycle as completion, with overrun left unchanged.
REQ-028 SHALL respond to a frame_tick while busy as follows: set overrun, drop any grant the next cycle, relatch pending from upd_req and enter SCAN.
REQ-029 SHALL keep upd_gnt at most one-hot at all times and all-zero outside GRANT.
REQ-030 SHALL clear overrun in the cycle after overrun_clr=1; a set event in the same cycle wins.
REQ-031 SHALL produce pixel_rgb one cycle after its inputs, equal to layer_rgb of the lowest-index i with layer_valid[i]=1, else BG_RGB.
REQ-032 Timeout counter width: SHALL be $clog2(TIMEOUT)+1 bits, reset on each grant.

Reset
REQ-033 SHALL, while reset=0, force the FSM to IDLE, pending=0, upd_gnt=0, pixel_rgb=BG_RGB, frame_tick=0, frame_count=0, busy=0, overrun=0, and both synchronizer flops to 1.
REQ-034 SHALL abandon any in-flight grant immediately on reset assertion, with no done or overrun side effects.
REQ-035 SHALL treat the first synchronized vsync falling edge after reset release as a normal frame start.

Structure
REQ-036 SHALL take state encoding, NUM_REQ, TIMEOUT and BG_RGB defaults from shared package pong_pkg.
REQ-037 SHALL implement the synchronizer and edge detector as sub-module vsync_edge (ports clk, reset, vsync_in, fall_pulse).
REQ-038 SHALL keep the scheduler and the layer merge in this module.

Verification
REQ-039 SHALL verify this sequence: upd_req=4'b1010, vsync falls, each requester pulses done 3 cycles after its grant -> gnt[1] then gnt[3], each high for 3 cycles; busy falls 1 cycle after SCAN; overrun=0.
REQ-040 SHALL verify timeout: upd_req=4'b0001, done never pulsed -> gnt[0] high for exactly 1024 cycles, then overrun=1, busy=0.
REQ-041 SHALL verify overlapping frames: a second vsync fall while gnt[2] is high -> gnt drops, overrun=1, pending relatched, frame_count=2.
REQ-042 SHALL verify the layer merge: layer_valid=4'b0110, layer1=3'b100, layer2=3'b010 -> pixel_rgb=3'b100 one cycle later; layer_valid=0 -> pixel_rgb=BG_RGB.
REQ-043 SHALL verify reset mid-grant: reset=0 during GRANT -> all outputs at reset values while reset is low; after release, the next vsync fall gives frame_count=1.
REQ-044 SHALL verify wrap: frame_count preloaded to 16'hFFFF by forcing, then one frame -> frame_count=0.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and defaults for the frame scheduler and its helpers.
// No logic of its own; zero latency.
// No flow control; constants only.
package pong_pkg;

    // Scheduler FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_GRANT = 2'd2
    } sched_state_t;

    localparam int             NUM_REQ_DEF = 4;
    localparam int             TIMEOUT_DEF = 1024;
    localparam logic [2:0]     BG_RGB_DEF  = 3'b000;
    localparam int             RGB_W       = 3;

endpackage

// File: rtl/vsync_edge.sv
// Two-flop synchronizer for the VGA vsync plus falling-edge detector.
// fall_pulse is combinational off the synchronized history: 2 clocks after the pin falls.
// No backpressure; one pulse per falling edge.
module vsync_edge (
    input  logic clk,
    input  logic reset,
    input  logic vsync_in,
    output logic fall_pulse
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Synchronize vsync and keep one cycle of history; idle level of vsync is high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= vsync_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign fall_pulse = prev_q & ~sync2_q;

endmodule

// File: rtl/frame_scheduler.sv
// Per-frame update-slot scheduler (lowest-index-first, one grant at a time) plus pixel layer merge.
// frame_tick 1 clk after synchronized vsync fall; grant 2 clks after tick; pixel_rgb 1 clk after inputs.
// Requesters hold a grant until upd_done or TIMEOUT cycles; a new frame while busy preempts and flags overrun.
module frame_scheduler
    import pong_pkg::*;
#(
    parameter int         NUM_REQ = NUM_REQ_DEF,
    parameter int         TIMEOUT = TIMEOUT_DEF,
    parameter logic [2:0] BG_RGB  = BG_RGB_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     vga_vsync,
    input  logic [NUM_REQ-1:0]       upd_req,
    input  logic [NUM_REQ-1:0]       upd_done,
    output logic [NUM_REQ-1:0]       upd_gnt,
    input  logic [RGB_W*NUM_REQ-1:0] layer_rgb,
    input  logic [NUM_REQ-1:0]       layer_valid,
    output logic [RGB_W-1:0]         pixel_rgb,
    output logic                     frame_tick,
    output logic [15:0]              frame_count,
    output logic                     busy,
    output logic                     overrun,
    input  logic                     overrun_clr
);

    localparam int             TW       = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);

    sched_state_t       state_q, state_d;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] pend_low;
    logic [TW-1:0]      timer_q, timer_d;
    logic               ovr_set;
    logic               done_k;
    logic               tmo;
    logic               fall_pulse;
    logic               frame_tick_q;
    logic [15:0]        frame_count_q;
    logic               overrun_q;
    logic [RGB_W-1:0]   pixel_q, pixel_d;

    vsync_edge u_vsync_edge (
        .clk        (clk),
        .reset      (reset),
        .vsync_in   (vga_vsync),
        .fall_pulse (fall_pulse)
    );

    // Isolate the lowest pending requester; only the granted requester's done counts
    assign pend_low = pending_q & (~pending_q + NUM_REQ'(1));
    assign done_k   = |(upd_done & gnt_q);
    assign tmo      = (timer_q == TMO_LAST);

    // Frame start pulse and frame counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_tick_q  <= 1'b0;
            frame_count_q <= 16'h0000;
        end else begin
            frame_tick_q <= fall_pulse;
            if (frame_tick_q) begin
                frame_count_q <= frame_count_q + 16'h0001;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and scheduler datapath next values
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        gnt_d     = gnt_q;
        timer_d   = timer_q;
        ovr_set   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_tick_q) begin
                    pending_d = upd_req;
                    state_d   = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (frame_tick_q) begin
                    // New frame before the previous one finished its schedule
                    ovr_set   = 1'b1;
                    pending_d = upd_req;
                    gnt_d     = '0;
                end else if (pending_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gnt_d   = pend_low;
                    timer_d = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (frame_tick_q) begin
                    ovr_set   = 1'b1;
                    pending_d = upd_req;
                    gnt_d     = '0;
                    state_d   = ST_SCAN;
                end else if (done_k || tmo) begin
                    // A done arriving on the timeout cycle still counts as completion
                    ovr_set   = ~done_k;
                    gnt_d     = '0;
                    pending_d = pending_q & ~gnt_q;
                    state_d   = ST_SCAN;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                pending_d = '0;
                gnt_d     = '0;
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q != ST_IDLE);
    end

    // Scheduler datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
            gnt_q     <= '0;
            timer_q   <= '0;
        end else begin
            pending_q <= pending_d;
            gnt_q     <= gnt_d;
            timer_q   <= timer_d;
        end
    end

    // Sticky overrun: a set event beats a simultaneous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun_q <= 1'b0;
        end else if (ovr_set) begin
            overrun_q <= 1'b1;
        end else if (overrun_clr) begin
            overrun_q <= 1'b0;
        end
    end

    // Layer merge: lowest valid layer index is on top
    always_comb begin
        pixel_d = BG_RGB;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (layer_valid[i]) begin
                pixel_d = layer_rgb[RGB_W*i +: RGB_W];
            end
        end
    end

    // Merged pixel register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pixel_q <= BG_RGB;
        end else begin
            pixel_q <= pixel_d;
        end
    end

    assign upd_gnt     = gnt_q;
    assign pixel_rgb   = pixel_q;
    assign frame_tick  = frame_tick_q;
    assign frame_count = frame_count_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler with default parameters.
// Inputs driven on the falling clock edge, outputs sampled on the falling edge.
// Summary line reports comparison and error counts.
module tb_frame_scheduler;

    logic        clk;
    logic        reset;
    logic        vga_vsync;
    logic [3:0]  upd_req;
    logic [3:0]  upd_done;
    logic [3:0]  upd_gnt;
    logic [11:0] layer_rgb;
    logic [3:0]  layer_valid;
    logic [2:0]  pixel_rgb;
    logic        frame_tick;
    logic [15:0] frame_count;
    logic        busy;
    logic        overrun;
    logic        overrun_clr;

    int checks = 0;
    int errors = 0;

    frame_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .vga_vsync   (vga_vsync),
        .upd_req     (upd_req),
        .upd_done    (upd_done),
        .upd_gnt     (upd_gnt),
        .layer_rgb   (layer_rgb),
        .layer_valid (layer_valid),
        .pixel_rgb   (pixel_rgb),
        .frame_tick  (frame_tick),
        .frame_count (frame_count),
        .busy        (busy),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Hold vsync low for four cycles starting at a falling clock edge; returns at a falling edge
    task automatic pulse_vsync();
        vga_vsync = 1'b0;
        repeat (4) @(negedge clk);
        vga_vsync = 1'b1;
    endtask

    // Wait (bounded) until some grant is visible
    task automatic wait_gnt(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (upd_gnt != 4'b0000) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (upd_gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b want 0000", upd_gnt); end
        checks++; if (pixel_rgb !== 3'b000) begin errors++; $display("FAIL reset_pixel got %b want 000", pixel_rgb); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", frame_tick); end
        checks++; if (frame_count !== 16'h0000) begin errors++; $display("FAIL reset_fcount got %h want 0000", frame_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_layer_merge();
        logic [3:0] vals [4];
        logic [2:0] exps [4];
        logic [2:0] prev;
        vals = '{4'b0110, 4'b0000, 4'b1000, 4'b1111};
        exps = '{3'b100, 3'b000, 3'b001, 3'b111};
        layer_rgb = {3'b001, 3'b010, 3'b100, 3'b111};
        prev = pixel_rgb;
        for (int i = 0; i < 4; i++) begin
            layer_valid = vals[i];
            #1;
            checks++; if (pixel_rgb !== prev) begin errors++; $display("FAIL merge_latency[%0d] got %b want %b", i, pixel_rgb, prev); end
            @(negedge clk);
            checks++; if (pixel_rgb !== exps[i]) begin errors++; $display("FAIL merge[%0d] got %b want %b", i, pixel_rgb, exps[i]); end
            prev = exps[i];
        end
        layer_valid = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_sequence();
        logic [3:0] exp_g [2];
        bit seen;
        int hi;
        exp_g = '{4'b0010, 4'b1000};
        upd_req = 4'b1010;
        pulse_vsync();
        for (int g = 0; g < 2; g++) begin
            wait_gnt(seen);
            checks++; if (!seen || upd_gnt !== exp_g[g]) begin errors++; $display("FAIL seq_gnt[%0d] got %b want %b", g, upd_gnt, exp_g[g]); end
            hi = 1;
            @(negedge clk);
            if (upd_gnt === exp_g[g]) hi++;
            upd_done = (g == 0) ? 4'b0100 : 4'b0001;   // non-granted done must be ignored
            @(negedge clk);
            if (upd_gnt === exp_g[g]) hi++;
            upd_done = exp_g[g];
            @(negedge clk);
            upd_done = 4'b0000;
            checks++; if (hi != 3 || upd_gnt !== 4'b0000) begin errors++; $display("FAIL seq_hi[%0d] got %0d cycles gnt %b want 3 cycles gnt 0000", g, hi, upd_gnt); end
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL seq_busy_scan got %b want 1", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL seq_busy_idle got %b want 0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL seq_overrun got %b want 0", overrun); end
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL seq_fcount got %0d want 1", frame_count); end
    endtask

    task automatic test_timeout(input bit tie, input logic [15:0] exp_fc);
        bit seen;
        int hi;
        upd_req = 4'b0001;
        pulse_vsync();
        wait_gnt(seen);
        checks++; if (!seen || upd_gnt !== 4'b0001) begin errors++; $display("FAIL tmo_gnt got %b want 0001", upd_gnt); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL tmo_overrun_early got %b want 0", overrun); end
        hi = 0;
        while (upd_gnt === 4'b0001 && hi < 1100) begin
            hi++;
            if (tie && hi == 1024) upd_done = 4'b0001;
            @(negedge clk);
            upd_done = 4'b0000;
        end
        checks++; if (hi != 1024) begin errors++; $display("FAIL tmo_len got %0d want 1024", hi); end
        checks++; if (overrun !== !tie) begin errors++; $display("FAIL tmo_overrun got %b want %b", overrun, !tie); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_busy got %b want 0", busy); end
        checks++; if (frame_count !== exp_fc) begin errors++; $display("FAIL tmo_fcount got %0d want %0d", frame_count, exp_fc); end
    endtask

    task automatic test_overrun_clr();
        overrun_clr = 1'b1;
        #1;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL clr_sync got %b want 1", overrun); end
        @(negedge clk);
        overrun_clr = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL clr got %b want 0", overrun); end
    endtask

    task automatic test_overlap();
        bit seen;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        upd_req = 4'b0100;
        pulse_vsync();
        wait_gnt(seen);
        checks++; if (!seen || upd_gnt !== 4'b0100) begin errors++; $display("FAIL ovl_gnt2 got %b want 0100", upd_gnt); end
        upd_req = 4'b1001;
        pulse_vsync();
        checks++; if (upd_gnt !== 4'b0000) begin errors++; $display("FAIL ovl_drop got %b want 0000", upd_gnt); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovl_overrun got %b want 1", overrun); end
        checks++; if (frame_count !== 16'd2) begin errors++; $display("FAIL ovl_fcount got %0d want 2", frame_count); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ovl_busy got %b want 1", busy); end
        @(negedge clk);
        checks++; if (upd_gnt !== 4'b0001) begin errors++; $display("FAIL ovl_relatch0 got %b want 0001", upd_gnt); end
        upd_done = 4'b0001;
        @(negedge clk);
        upd_done = 4'b0000;
        @(negedge clk);
        checks++; if (upd_gnt !== 4'b1000) begin errors++; $display("FAIL ovl_relatch3 got %b want 1000", upd_gnt); end
        upd_done = 4'b1000;
        @(negedge clk);
        upd_done = 4'b0000;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovl_idle got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_grant();
        bit seen;
        layer_rgb   = {3'b001, 3'b010, 3'b100, 3'b111};
        layer_valid = 4'b0001;
        upd_req     = 4'b0001;
        pulse_vsync();
        wait_gnt(seen);
        checks++; if (!seen || pixel_rgb !== 3'b111) begin errors++; $display("FAIL rst_pre gnt %b pixel %b want gnt set pixel 111", upd_gnt, pixel_rgb); end
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) #1; else repeat (3) @(negedge clk);
            checks++; if (upd_gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt[%0d] got %b want 0000", k, upd_gnt); end
            checks++; if (pixel_rgb !== 3'b000) begin errors++; $display("FAIL rst_pixel[%0d] got %b want 000", k, pixel_rgb); end
            checks++; if ({frame_tick, busy, overrun} !== 3'b000) begin errors++; $display("FAIL rst_flags[%0d] tick/busy/ovr got %b want 000", k, {frame_tick, busy, overrun}); end
            checks++; if (frame_count !== 16'h0000) begin errors++; $display("FAIL rst_fcount[%0d] got %0d want 0", k, frame_count); end
        end
        reset       = 1'b1;
        layer_valid = 4'b0000;
        upd_req     = 4'b0000;
        @(negedge clk);
        pulse_vsync();
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL rst_after_fcount got %0d want 1", frame_count); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_after_overrun got %b want 0", overrun); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || upd_gnt !== 4'b0000) begin errors++; $display("FAIL rst_after_idle busy %b gnt %b want 0 0000", busy, upd_gnt); end
    endtask

    task automatic test_wrap();
        int ticks;
        int tick_at;
        force dut.frame_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_count_q;
        #1;
        checks++; if (frame_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload got %h want ffff", frame_count); end
        @(negedge clk);
        ticks   = 0;
        tick_at = 0;
        vga_vsync = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 4) vga_vsync = 1'b1;
            if (frame_tick === 1'b1) begin
                ticks++;
                tick_at = i;
            end
        end
        checks++; if (ticks != 1 || tick_at != 3) begin errors++; $display("FAIL wrap_tick got %0d pulses at %0d want 1 at 3", ticks, tick_at); end
        checks++; if (frame_count !== 16'h0000) begin errors++; $display("FAIL wrap got %h want 0000", frame_count); end
    endtask

    initial begin
        reset       = 1'b0;
        vga_vsync   = 1'b1;
        upd_req     = 4'b0000;
        upd_done    = 4'b0000;
        layer_rgb   = 12'h000;
        layer_valid = 4'b0000;
        overrun_clr = 1'b0;

        test_reset();
        test_layer_merge();
        test_sequence();
        test_timeout(1'b0, 16'd2);
        test_overrun_clr();
        test_timeout(1'b1, 16'd3);
        test_overlap();
        test_reset_mid_grant();
        test_wrap();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
